// File: rtl/branch_predict_unit.sv
// MEM-stage branch resolver with a 2-bit saturating-counter BHT for IF-stage
// prediction, registered mispredict/redirect and saturating perf counters.
module branch_predict_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic [XLEN-1:0]   mem_target,
    input  logic              mem_zero,
    input  logic [XLEN-1:0]   mem_aluresult,
    input  logic [2:0]        mem_funct3,
    input  logic              mem_isbranch,
    input  logic              mem_isjump,
    input  logic              mem_pred_taken,
    input  logic              bht_clear,
    output logic              branch,
    output logic              pcsrc,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             cond_taken;
    logic             cond_legal;
    logic             resolve;
    logic             resolve_br;
    logic             bht_upd;
    logic             mis_next;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt;
    logic [XLEN-1:0]  fall_pc;
    logic [XLEN-1:0]  redirect_nxt;
    logic             unused_bits;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign mem_idx = mem_pc[IDX_W+1:2];

    // Lookup reads the stored counter directly, so a same-cycle update is
    // not visible until the next cycle.
    assign pred_taken = bht[if_idx][1];

    always_comb begin
        cond_taken = 1'b0;
        cond_legal = 1'b1;
        unique case (mem_funct3)
            3'b000:         cond_taken = mem_zero;
            3'b001:         cond_taken = ~mem_zero;
            3'b100, 3'b110: cond_taken = mem_aluresult[0];
            3'b101, 3'b111: cond_taken = ~mem_aluresult[0];
            default:        cond_legal = 1'b0;
        endcase
    end

    // A pending mispredict squashes whatever wrong-path op sits in MEM.
    assign resolve    = mem_valid & (mem_isbranch | mem_isjump) & ~mispredict;
    assign resolve_br = resolve & mem_isbranch & ~mem_isjump;
    assign bht_upd    = resolve_br & cond_legal;

    always_comb begin
        pcsrc = 1'b0;
        if (resolve) begin
            if (mem_isjump)
                pcsrc = 1'b1;
            else
                pcsrc = cond_taken & cond_legal;
        end
    end

    assign branch = mem_isbranch & mem_valid;

    assign mis_next     = resolve & (pcsrc != mem_pred_taken);
    assign fall_pc      = mem_pc + XLEN'(4);
    assign redirect_nxt = pcsrc ? mem_target : fall_pc;

    assign ctr_cur = bht[mem_idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (cond_taken) begin
            if (ctr_cur != 2'b11)
                ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00)
                ctr_nxt = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_INIT;
        end else if (bht_clear) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_INIT;
        end else if (bht_upd) begin
            bht[mem_idx] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= mis_next;
            if (mis_next)
                redirect_pc <= redirect_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve_br && !(&branch_cnt))
                branch_cnt <= branch_cnt + PERF_W'(1);
            if (mis_next && !(&mispred_cnt))
                mispred_cnt <= mispred_cnt + PERF_W'(1);
        end
    end

    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                           mem_aluresult[XLEN-1:1]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: BHT training, mispredict/redirect,
// squash, illegal funct3, clear priority, PC wrap and async reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_target;
    logic        mem_zero;
    logic [31:0] mem_aluresult;
    logic [2:0]  mem_funct3;
    logic        mem_isbranch;
    logic        mem_isjump;
    logic        mem_pred_taken;
    logic        bht_clear;
    logic        branch;
    logic        pcsrc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int tests = 0;
    int fails = 0;

    branch_predict_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_target     (mem_target),
        .mem_zero       (mem_zero),
        .mem_aluresult  (mem_aluresult),
        .mem_funct3     (mem_funct3),
        .mem_isbranch   (mem_isbranch),
        .mem_isjump     (mem_isjump),
        .mem_pred_taken (mem_pred_taken),
        .bht_clear      (bht_clear),
        .branch         (branch),
        .pcsrc          (pcsrc),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid      = 1'b0;
        mem_pc         = '0;
        mem_target     = '0;
        mem_zero       = 1'b0;
        mem_aluresult  = '0;
        mem_funct3     = 3'b000;
        mem_isbranch   = 1'b0;
        mem_isjump     = 1'b0;
        mem_pred_taken = 1'b0;
        bht_clear      = 1'b0;
    endtask

    task automatic op(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [2:0] f3, input logic z,
                      input logic [31:0] alu, input logic isb,
                      input logic isj, input logic pred);
        mem_valid      = 1'b1;
        mem_pc         = pc;
        mem_target     = tgt;
        mem_funct3     = f3;
        mem_zero       = z;
        mem_aluresult  = alu;
        mem_isbranch   = isb;
        mem_isjump     = isj;
        mem_pred_taken = pred;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();
        #12;
        rst_n = 1'b1;
        cyc();

        // reset state
        chk("rst_pred", pred_taken, 0);
        chk("rst_mis", mispredict, 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_bcnt", branch_cnt, 0);
        chk("rst_mcnt", mispred_cnt, 0);

        // BEQ taken, predicted not-taken
        op(32'h100, 32'h80, 3'b000, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("beq_pcsrc", pcsrc, 1);
        chk("beq_branch", branch, 1);
        chk("beq_nobypass", pred_taken, 0);
        cyc();
        chk("beq_mis", mispredict, 1);
        chk("beq_redir", redirect_pc, 32'h80);
        chk("beq_pred", pred_taken, 1);
        chk("beq_bcnt", branch_cnt, 1);
        chk("beq_mcnt", mispred_cnt, 1);
        idle();
        cyc();
        chk("pulse_one", mispredict, 0);

        // train to 3, then one correct not-taken -> 2
        for (int i = 0; i < 5; i++) begin
            op(32'h100, 32'h80, 3'b000, 1'b1, 0, 1'b1, 1'b0, 1'b1);
            cyc();
            chk("train_mis", mispredict, 0);
        end
        op(32'h100, 32'h80, 3'b000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("nt_pcsrc", pcsrc, 0);
        cyc();
        chk("nt_mis", mispredict, 0);
        chk("nt_pred", pred_taken, 1);
        chk("nt_bcnt", branch_cnt, 7);

        // BNE not-taken, predicted taken; aliases idx 0 -> ctr 1
        op(32'h200, 32'h180, 3'b001, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        chk("bne_pcsrc", pcsrc, 0);
        cyc();
        chk("bne_mis", mispredict, 1);
        chk("bne_redir", redirect_pc, 32'h204);
        chk("bne_pred", pred_taken, 0);

        // squashed branch during the mispredict cycle
        op(32'h100, 32'h80, 3'b000, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("sq_pcsrc", pcsrc, 0);
        chk("sq_branch", branch, 1);
        cyc();
        chk("sq_mis", mispredict, 0);
        chk("sq_bcnt", branch_cnt, 8);
        chk("sq_mcnt", mispred_cnt, 2);
        chk("sq_pred", pred_taken, 0);

        // JAL: mispredict, no BHT change
        op(32'h300, 32'h400, 3'b000, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("jal_pcsrc", pcsrc, 1);
        chk("jal_branch", branch, 0);
        cyc();
        chk("jal_mis", mispredict, 1);
        chk("jal_redir", redirect_pc, 32'h400);
        chk("jal_pred", pred_taken, 0);
        chk("jal_mcnt", mispred_cnt, 3);
        chk("jal_bcnt", branch_cnt, 8);
        idle();
        cyc();

        // BLTU taken at idx 1 (ctr 1 -> 2)
        if_pc = 32'h104;
        op(32'h104, 32'h40, 3'b110, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        chk("bltu_pcsrc", pcsrc, 1);
        cyc();
        chk("bltu_mis", mispredict, 0);
        chk("bltu_pred", pred_taken, 1);

        // funct3 010: never taken, no update; BLT-style decode must not leak
        op(32'h104, 32'h40, 3'b010, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("f010_pcsrc", pcsrc, 0);
        cyc();
        chk("f010_mis", mispredict, 0);
        op(32'h104, 32'h40, 3'b010, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("f010_pred", pred_taken, 1);

        // clear wins over same-cycle update (update would give 3)
        op(32'h104, 32'h40, 3'b000, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        bht_clear = 1'b1;
        cyc();
        bht_clear = 1'b0;
        chk("clr_pred", pred_taken, 0);
        chk("clr_mcnt", mispred_cnt, 3);
        op(32'h104, 32'h40, 3'b000, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("clr_retrain", pred_taken, 1);
        idle();
        cyc();

        // redirect wraps past top of address space
        op(32'hFFFF_FFFC, 32'h10, 3'b000, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("wrap_mis", mispredict, 1);
        chk("wrap_redir", redirect_pc, 0);
        chk("wrap_mcnt", mispred_cnt, 5);

        // async reset mid-pulse
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst_mis", mispredict, 0);
        chk("arst_redir", redirect_pc, 0);
        chk("arst_bcnt", branch_cnt, 0);
        chk("arst_mcnt", mispred_cnt, 0);
        chk("arst_pred", pred_taken, 0);
        chk("arst_pcsrc", pcsrc, 0);
        #3;
        rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
